fpu_32_divider: RTL and testbench

- Iterative single-precision IEEE-754 divider computing res = X / Y.
- Companion to the combinational fpu_32_multiplier: it provides the inverse operation for the same FPU and uses the same operand, result and flag naming.
- Multi-cycle operation with a start/done handshake, one restoring-division quotient bit per clock, and a fixed latency.

---
 rtl/fpu_32_divider.sv | 211 +++++++++++++++++++++
 tb/tb_fpu_32_divider.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fpu_32_divider.sv
// fpu_32_divider
// Iterative IEEE-754 single-precision divider, res = X / Y.
// Restoring division produces one quotient bit per clock. The latency is
// fixed at 28 clocks from the start edge to the done pulse.
// Denormal operands are treated as signed zero. Results below the minimum
// normal are flushed to signed zero.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start             operation request, sampled only while busy = 0
//   X, Y              dividend and divisor (IEEE-754 single)
//   busy              operation in progress
//   done              one-cycle pulse; res and flags are valid from this cycle
//   res               quotient; holds its value until the next done
//   overflow_flag     finite result above max normal, replaced by +/-inf
//   underflow_flag    nonzero result below min normal, flushed to +/-0
//   div_by_zero_flag  finite nonzero divided by zero
//   invalid_flag      NaN operand, 0/0 or inf/inf
module fpu_32_divider #(
    parameter int QBITS = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] X,
    input  logic [31:0] Y,
    output logic        busy,
    output logic        done,
    output logic [31:0] res,
    output logic        overflow_flag,
    output logic        underflow_flag,
    output logic        div_by_zero_flag,
    output logic        invalid_flag
);

    typedef enum logic [1:0] {IDLE, SETUP, DIV, FINISH} state_t;
    typedef enum logic [2:0] {SP_NONE, SP_NAN, SP_INF, SP_DBZ, SP_ZERO} special_t;

    state_t             state_q;
    special_t           special_q, special_d;
    logic [31:0]        x_q, y_q;
    logic               sign_q;
    logic signed [9:0]  exp_q, exp_d;
    logic [23:0]        my_q;
    logic [24:0]        rem_q;
    logic [QBITS-1:0]   quo_q;
    logic [4:0]         cnt_q;

    // Operand classification on the latched operands, used in SETUP.
    logic [7:0]  ex, ey;
    logic [22:0] fx, fy;
    logic        x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;

    always_comb begin
        ex = x_q[30:23];
        ey = y_q[30:23];
        fx = x_q[22:0];
        fy = y_q[22:0];
        // A zero exponent covers both true zeros and denormals.
        x_zero = (ex == 8'h00);
        y_zero = (ey == 8'h00);
        x_inf  = (ex == 8'hFF) && (fx == 23'h0);
        y_inf  = (ey == 8'hFF) && (fy == 23'h0);
        x_nan  = (ex == 8'hFF) && (fx != 23'h0);
        y_nan  = (ey == 8'hFF) && (fy != 23'h0);
        exp_d  = $signed({2'b00, ex}) - $signed({2'b00, ey}) + 10'sd127;
        // NOTE: every variable assigned in always_comb gets a default first so no path infers a latch.
        special_d = SP_NONE;
        if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf))
            special_d = SP_NAN;
        else if (x_inf)
            special_d = SP_INF;
        else if (y_zero)
            special_d = SP_DBZ;
        else if (x_zero || y_inf)
            special_d = SP_ZERO;
    end

    // One restoring-division step. rem_q already holds the doubled remainder,
    // or Mx on the first step. Because rem < My < 2^24, the doubling fits in 25 bits.
    logic        q_bit;
    logic [24:0] rem_after, rem_d;

    always_comb begin
        q_bit     = (rem_q >= {1'b0, my_q});
        rem_after = q_bit ? (rem_q - {1'b0, my_q}) : rem_q;
        rem_d     = {rem_after[23:0], 1'b0};
    end

    // Normalise, round to nearest even, and pack the result.
    logic [QBITS-1:0]  quo_n;
    logic signed [9:0] exp_n, exp_r;
    logic [23:0]       sig;
    logic              guard, sticky, round_up;
    logic [24:0]       sig_r;
    logic [22:0]       frac;
    logic [31:0]       fin_res;
    logic [3:0]        fin_flags;   // {overflow, underflow, div_by_zero, invalid}

    always_comb begin
        quo_n    = quo_q[QBITS-1] ? quo_q : {quo_q[QBITS-2:0], 1'b0};
        exp_n    = quo_q[QBITS-1] ? exp_q : exp_q - 10'sd1;
        sig      = quo_n[25:2];
        guard    = quo_n[1];
        sticky   = quo_n[0] | (rem_q != 25'h0);
        round_up = guard & (sticky | sig[0]);
        sig_r    = {1'b0, sig} + 25'(round_up);
        // A rounding carry out leaves 1.000..0, so shift right and bump the exponent.
        if (sig_r[24]) begin
            frac  = sig_r[23:1];
            exp_r = exp_n + 10'sd1;
        end else begin
            frac  = sig_r[22:0];
            exp_r = exp_n;
        end
        fin_flags = 4'b0000;
        fin_res   = {sign_q, exp_r[7:0], frac};
        case (special_q)
            SP_NAN: begin
                fin_res   = 32'h7FC0_0000;
                fin_flags = 4'b0001;
            end
            SP_INF:  fin_res = {sign_q, 8'hFF, 23'h0};
            SP_DBZ: begin
                fin_res   = {sign_q, 8'hFF, 23'h0};
                fin_flags = 4'b0010;
            end
            SP_ZERO: fin_res = {sign_q, 31'h0};
            default: begin
                if (exp_r >= 10'sd255) begin
                    fin_res   = {sign_q, 8'hFF, 23'h0};
                    fin_flags = 4'b1000;
                end else if (exp_r <= 10'sd0) begin
                    fin_res   = {sign_q, 31'h0};
                    fin_flags = 4'b0100;
                end
            end
        endcase
    end

    // NOTE: the datapath registers are reset along with the control state so
    // every register has a defined value after reset. A reset mid-operation
    // simply discards the partial quotient.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            special_q        <= SP_NONE;
            x_q              <= 32'h0;
            y_q              <= 32'h0;
            sign_q           <= 1'b0;
            exp_q            <= 10'sd0;
            my_q             <= 24'h0;
            rem_q            <= 25'h0;
            quo_q            <= '0;
            cnt_q            <= 5'd0;
            busy             <= 1'b0;
            done             <= 1'b0;
            res              <= 32'h0;
            overflow_flag    <= 1'b0;
            underflow_flag   <= 1'b0;
            div_by_zero_flag <= 1'b0;
            invalid_flag     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        x_q              <= X;
                        y_q              <= Y;
                        busy             <= 1'b1;
                        overflow_flag    <= 1'b0;
                        underflow_flag   <= 1'b0;
                        div_by_zero_flag <= 1'b0;
                        invalid_flag     <= 1'b0;
                        state_q          <= SETUP;
                    end
                end
                SETUP: begin
                    sign_q    <= x_q[31] ^ y_q[31];
                    exp_q     <= exp_d;
                    my_q      <= {1'b1, fy};
                    rem_q     <= {2'b01, fx};
                    quo_q     <= '0;
                    cnt_q     <= 5'd0;
                    special_q <= special_d;
                    state_q   <= DIV;
                end
                DIV: begin
                    quo_q <= {quo_q[QBITS-2:0], q_bit};
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'(QBITS - 1))
                        state_q <= FINISH;
                end
                FINISH: begin
                    res              <= fin_res;
                    overflow_flag    <= fin_flags[3];
                    underflow_flag   <= fin_flags[2];
                    div_by_zero_flag <= fin_flags[1];
                    invalid_flag     <= fin_flags[0];
                    done             <= 1'b1;
                    busy             <= 1'b0;
                    state_q          <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_32_divider.sv
// tb_fpu_32_divider
// Self-checking bench for fpu_32_divider. It runs a table of operand/result
// vectors back to back, with each start asserted in the previous done cycle.
// Hand-written sequences cover an ignored restart while busy and an async
// reset mid-operation. Expected results go into a scoreboard queue when the
// stimulus is driven, and a monitor pops and compares them on every done.
module tb_fpu_32_divider;

    localparam logic [3:0] OVF = 4'b1000;
    localparam logic [3:0] UNF = 4'b0100;
    localparam logic [3:0] DBZ = 4'b0010;
    localparam logic [3:0] INV = 4'b0001;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] X, Y;
    logic        busy, done;
    logic [31:0] res;
    logic        overflow_flag, underflow_flag, div_by_zero_flag, invalid_flag;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[$];

    fpu_32_divider #(.QBITS(26)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .X                (X),
        .Y                (Y),
        .busy             (busy),
        .done             (done),
        .res              (res),
        .overflow_flag    (overflow_flag),
        .underflow_flag   (underflow_flag),
        .div_by_zero_flag (div_by_zero_flag),
        .invalid_flag     (invalid_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, expv);
        end
    endtask

    // Scoreboard monitor: each done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got res %08h, expected no done", res);
            end else begin
                mon_e = sb.pop_front();
                check("res", res, mon_e.res);
                check("flags", {28'h0, overflow_flag, underflow_flag, div_by_zero_flag, invalid_flag},
                      {28'h0, mon_e.flg});
            end
        end
    end

    // Issue one operation and wait for its done. Call it just after a falling
    // edge. With poke set, a second start carrying different operands is
    // pulsed mid-operation and must be ignored.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] er, input logic [3:0] ef, input bit poke);
        int   lat, busy_cyc, d0;
        exp_t e;
        e.res = er;
        e.flg = ef;
        X     = x;
        Y     = y;
        start = 1'b1;
        sb.push_back(e);
        d0       = done_cnt;
        lat      = 0;
        busy_cyc = 0;
        while (done_cnt == d0 && lat < 60) begin
            @(negedge clk);
            #1;
            lat++;
            start = 1'b0;
            if (poke && lat == 4) begin
                X     = 32'h40C0_0000;
                Y     = 32'h4040_0000;
                start = 1'b1;
            end
            if (busy) busy_cyc++;
        end
        if (done_cnt == d0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: got no done within %0d cycles, expected done at 29", lat);
            sb.delete();
        end else begin
            check("latency", 32'(lat), 32'd29);
            check("busy_cycles", 32'(busy_cyc), 32'd28);
        end
    endtask

    initial begin
        vecs = '{
            '{32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 4'b0000},
            '{32'hBF80_0000, 32'h4040_0000, 32'hBEAA_AAAB, 4'b0000},
            '{32'h40C0_0000, 32'h4040_0000, 32'h4000_0000, 4'b0000},
            '{32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, DBZ},
            '{32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, INV},
            '{32'h7F80_0000, 32'h4020_0000, 32'h7F80_0000, 4'b0000},
            '{32'h7F00_0000, 32'h3F00_0000, 32'h7F80_0000, OVF},
            '{32'h0E00_0000, 32'h7100_0000, 32'h0000_0000, UNF},
            '{32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, INV},
            '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, INV},
            '{32'hFF80_0000, 32'h0000_0000, 32'hFF80_0000, 4'b0000},
            '{32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 4'b0000},
            '{32'hBF80_0000, 32'h7F80_0000, 32'h8000_0000, 4'b0000},
            '{32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 4'b0000},
            '{32'h3F80_0000, 32'hBF80_0000, 32'hBF80_0000, 4'b0000},
            '{32'h7F7F_FFFF, 32'h3F80_0000, 32'h7F7F_FFFF, 4'b0000},
            '{32'h0080_0000, 32'h3F80_0000, 32'h0080_0000, 4'b0000},
            '{32'h0080_0000, 32'h4000_0000, 32'h0000_0000, UNF},
            '{32'h8E00_0000, 32'h7100_0000, 32'h8000_0000, UNF},
            '{32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 4'b0000}
        };

        rst_n = 1'b0;
        start = 1'b0;
        X     = 32'h0;
        Y     = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);
        check("reset_res", res, 32'h0);
        check("reset_flags", {28'h0, overflow_flag, underflow_flag, div_by_zero_flag, invalid_flag}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        // First operation: done must be a single-cycle pulse.
        run_op(32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 4'b0000, 1'b0);
        @(negedge clk);
        #1;
        check("done_single_cycle", {31'h0, done}, 32'h0);
        check("idle_after_done", {31'h0, busy}, 32'h0);

        // Table vectors, each started in the done cycle of the previous one.
        foreach (vecs[i]) begin
            run_op(vecs[i].x, vecs[i].y, vecs[i].res, vecs[i].flg, 1'b0);
        end

        // A restart pulse with new operands while busy is ignored.
        @(negedge clk);
        #1;
        run_op(32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 4'b0000, 1'b1);
        repeat (35) @(negedge clk);
        #1;
        check("no_extra_done", 32'(sb.size()), 32'd0);

        // Asynchronous reset mid-operation abandons the operation without a done pulse.
        begin
            int d0;
            d0    = done_cnt;
            X     = 32'hBF80_0000;
            Y     = 32'h4040_0000;
            start = 1'b1;
            @(negedge clk);
            #1;
            start = 1'b0;
            repeat (9) @(negedge clk);
            #3;
            rst_n = 1'b0;
            #1;
            check("mid_reset_busy", {31'h0, busy}, 32'h0);
            check("mid_reset_done", {31'h0, done}, 32'h0);
            check("mid_reset_res", res, 32'h0);
            check("mid_reset_flags", {28'h0, overflow_flag, underflow_flag, div_by_zero_flag, invalid_flag}, 32'h0);
            repeat (2) @(negedge clk);
            #1;
            rst_n = 1'b1;
            repeat (35) @(negedge clk);
            #1;
            check("no_done_after_reset", 32'(done_cnt - d0), 32'd0);
        end
        run_op(32'h40C0_0000, 32'h4040_0000, 32'h4000_0000, 4'b0000, 1'b0);

        repeat (35) @(negedge clk);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
